// File: rtl/serial_echo_ctrl.sv
// serial_echo_ctrl: pops each received byte, adds INCREMENT and pushes it to the transmitter,
// with host flow control and stretched activity LEDs. Optional macro: SERIAL_ECHO_ERR_DROP_EN.
module serial_echo_ctrl #(
   parameter logic [7:0]  INCREMENT      = 8'd1,
   parameter int unsigned LED_HOLD_TICKS = 5000000,
   parameter int unsigned RD_LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_avail,
   input  logic [7:0]  rx_data,
   input  logic        rx_err,
   output logic        rx_rd,
   input  logic        tx_full,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        host_rts,
   output logic        host_cts,
   output logic        rx_led,
   output logic        tx_led,
`ifdef SERIAL_ECHO_ERR_DROP_EN
   output logic [15:0] err_cnt,
`endif
   output logic [15:0] echo_cnt
);

   typedef enum logic [2:0] {IDLE, READ, WAIT_DATA, HOLD, WRITE} state_t;

   localparam int unsigned   LW         = (LED_HOLD_TICKS > 2) ? $clog2(LED_HOLD_TICKS) : 1;
   localparam logic [LW-1:0] LED_RELOAD = LW'(LED_HOLD_TICKS - 1);
   localparam logic [1:0]    LAT_LAST   = 2'(RD_LATENCY - 1);

   state_t        state, state_next;
   logic [1:0]    lat_cnt;
   logic [7:0]    hold;
   logic [1:0]    rts_sync;
   logic          run;
   logic [LW-1:0] rx_led_cnt, tx_led_cnt;
   logic          capture, go_write;
`ifdef SERIAL_ECHO_ERR_DROP_EN
   logic          err_q;
   logic          drop;
`else
   logic          unused_err;
   assign unused_err = rx_err;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      rx_rd      = 1'b0;
      tx_wr      = 1'b0;
      capture    = 1'b0;
      go_write   = 1'b0;
`ifdef SERIAL_ECHO_ERR_DROP_EN
      drop       = 1'b0;
`endif
      case (state)
         IDLE:      if (rx_avail) state_next = READ;
         READ: begin
            rx_rd      = 1'b1;
            state_next = WAIT_DATA;
         end
         WAIT_DATA: if (lat_cnt == LAT_LAST) begin
            capture    = 1'b1;
            state_next = HOLD;
         end
         HOLD:
`ifdef SERIAL_ECHO_ERR_DROP_EN
            if (err_q) begin
               drop       = 1'b1;
               state_next = IDLE;
            end else
`endif
            if (!tx_full && rts_sync[1]) begin
               go_write   = 1'b1;
               state_next = WRITE;
            end
         WRITE: begin
            tx_wr      = 1'b1;
            state_next = IDLE;
         end
         default:   state_next = IDLE;
      endcase
   end

   // run keeps host_cts low while reset is asserted even though the FSM rests in IDLE
   assign host_cts = run & ((state == IDLE) | (state == READ) | ~tx_full);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run      <= 1'b0;
         rts_sync <= '0;
         lat_cnt  <= '0;
         hold     <= '0;
         tx_data  <= '0;
         echo_cnt <= '0;
      end else begin
         run      <= 1'b1;
         rts_sync <= {rts_sync[0], host_rts};
         if (state == READ)           lat_cnt <= '0;
         else if (state == WAIT_DATA) lat_cnt <= lat_cnt + 2'd1;
         if (capture)  hold     <= rx_data + INCREMENT;
         if (go_write) tx_data  <= hold;
         if (tx_wr)    echo_cnt <= echo_cnt + 16'd1;
      end
   end

`ifdef SERIAL_ECHO_ERR_DROP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q   <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (capture) err_q   <= rx_err;
         if (drop)    err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_led_cnt <= '0;
         tx_led_cnt <= '0;
      end else begin
         if (rx_rd)                  rx_led_cnt <= LED_RELOAD;
         else if (rx_led_cnt != '0)  rx_led_cnt <= rx_led_cnt - LW'(1);
         if (tx_wr)                  tx_led_cnt <= LED_RELOAD;
         else if (tx_led_cnt != '0)  tx_led_cnt <= tx_led_cnt - LW'(1);
      end
   end

   assign rx_led = (rx_led_cnt != '0) | rx_rd;
   assign tx_led = (tx_led_cnt != '0) | tx_wr;

endmodule

// File: tb/tb_serial_echo_ctrl.sv
// Bench for serial_echo_ctrl: transaction-level model of the echo path checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_serial_echo_ctrl;

   localparam int         L      = 1;
   localparam int         HOLD_T = 10;
   localparam logic [7:0] INC    = 8'd1;

   typedef struct packed { logic [7:0] data; logic err; } rx_item_t;

   logic        clk = 1'b0, rst = 1'b0;
   logic        rx_avail = 1'b0, rx_err = 1'b0, tx_full = 1'b0, host_rts = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_rd, tx_wr, host_cts, rx_led, tx_led;
   logic [7:0]  tx_data;
   logic [15:0] echo_cnt;
`ifdef SERIAL_ECHO_ERR_DROP_EN
   logic [15:0] err_cnt;
`endif

   serial_echo_ctrl #(.INCREMENT(INC), .LED_HOLD_TICKS(HOLD_T), .RD_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .rx_avail(rx_avail), .rx_data(rx_data), .rx_err(rx_err),
      .rx_rd(rx_rd), .tx_full(tx_full), .tx_data(tx_data), .tx_wr(tx_wr),
      .host_rts(host_rts), .host_cts(host_cts), .rx_led(rx_led), .tx_led(tx_led),
`ifdef SERIAL_ECHO_ERR_DROP_EN
      .err_cnt(err_cnt),
`endif
      .echo_cnt(echo_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_bad = 0;
   int n_wr = 0, n_rd = 0, n_drop = 0;
   int cyc = 0, since_rst = 0, rd_cyc = 0, wr_lat = 0;
   int last_rx = -1000, last_tx = -1000, drop_at = 0;
   logic inflight = 1'b0, prev_full = 1'b0, drop_pending = 1'b0;
   logic [7:0] last_data = '0;
   rx_item_t item;
   rx_item_t rxq[$];
   logic [7:0] exp_q[$];
   logic [7:0] wr_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the bench is the RX FIFO; each pop must come out once as data+INC, in order.
   always @(negedge clk) begin
      if (!rst) begin
         chk("reset_outputs", {rx_rd, tx_wr, tx_data, host_cts, rx_led, tx_led, echo_cnt}, '0);
`ifdef SERIAL_ECHO_ERR_DROP_EN
         chk("reset_err_cnt", err_cnt, 0);
`endif
         exp_q.delete();
         inflight = 1'b0; drop_pending = 1'b0;
         n_wr = 0; n_drop = 0; since_rst = 0;
         last_rx = cyc - 1000; last_tx = cyc - 1000; last_data = '0;
      end else begin
         cyc++; since_rst++;
`ifdef SERIAL_ECHO_ERR_DROP_EN
         if (drop_pending && cyc == drop_at) begin
            drop_pending = 1'b0; inflight = 1'b0; n_drop++;
         end
         chk("err_cnt", err_cnt, n_drop);
`endif
         chk("echo_cnt", echo_cnt, n_wr);
         chk("rx_led", rx_led, (rx_rd === 1'b1) || (cyc - last_rx < HOLD_T));
         chk("tx_led", tx_led, (tx_wr === 1'b1) || (cyc - last_tx < HOLD_T));
         if (since_rst > 1) chk("host_cts", host_cts, !inflight || !tx_full);
         if (rx_rd === 1'b1) begin
            chk("one_in_flight", inflight, 0);
            chk("rd_wr_overlap", tx_wr, 0);
            chk("rd_when_empty", rxq.size() != 0, 1);
            if (rxq.size() != 0) begin
               item = rxq.pop_front();
               rx_data = item.data; rx_err = item.err;
`ifdef SERIAL_ECHO_ERR_DROP_EN
               if (item.err) begin drop_pending = 1'b1; drop_at = cyc + L + 2; end
               else exp_q.push_back(item.data + INC);
`else
               exp_q.push_back(item.data + INC);
`endif
            end
            inflight = 1'b1; rd_cyc = cyc; last_rx = cyc; n_rd++;
         end
         if (tx_wr === 1'b1) begin
            chk("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q.pop_front());
            chk("wr_after_full", prev_full, 0);
            chk("wr_latency_min", (cyc - rd_cyc) >= 2 + L, 1);
            wr_lat = cyc - rd_cyc;
            last_data = tx_data; wr_log.push_back(tx_data);
            n_wr++; inflight = 1'b0; last_tx = cyc;
         end else begin
            chk("tx_data_hold", tx_data, last_data);
         end
      end
      prev_full = tx_full;
      rx_avail  = (rxq.size() != 0);
   end

   task automatic push(input logic [7:0] d, input logic e);
      rxq.push_back({d, e});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_wr(input int target, input int budget);
      int i = 0;
      while (n_wr < target && i < budget) begin @(posedge clk); #1; i++; end
      chk("wait_wr_timeout", n_wr >= target, 1);
   endtask

   task automatic wait_rd(input int target, input int budget);
      int i = 0;
      while (n_rd < target && i < budget) begin @(posedge clk); #1; i++; end
      chk("wait_rd_timeout", n_rd >= target, 1);
   endtask

   task automatic led_window(input int n, output int rx_hi, output int tx_hi,
                             output int rx_rise, output int tx_rise);
      logic pr = 1'b0, pt = 1'b0;
      rx_hi = 0; tx_hi = 0; rx_rise = 0; tx_rise = 0;
      repeat (n) begin
         @(negedge clk);
         if (rx_led) rx_hi++;
         if (tx_led) tx_hi++;
         if (rx_led && !pr) rx_rise++;
         if (tx_led && !pt) tx_rise++;
         pr = rx_led; pt = tx_led;
      end
      #1;
   endtask

   int base, rd0, rh, th, rr, tr;

   initial begin
      host_rts = 1'b1;
      idle(5);
      rst = 1'b1;

      // idle after reset: no pops, host clear to send
      idle(1000);
      chk("idle_no_rd", n_rd, 0);
      chk("idle_cts", host_cts, 1);

      // single echo
      base = n_wr;
      push(8'h53, 1'b0);
      wait_wr(base + 1, 20);
      chk("t2_data", last_data, 8'h54);
      chk("t2_latency_max", wr_lat <= 3 + L, 1);
      idle(1);
      chk("t2_echo_cnt", echo_cnt, 16'd1);
      chk("t2_single_rd", n_rd, 1);

      // wrap and back-to-back ordering
      base = n_wr;
      push(8'hFF, 1'b0);
      wait_wr(base + 1, 20);
      chk("t3_wrap", last_data, 8'h00);
      base = n_wr;
      push(8'h77, 1'b0); push(8'h10, 1'b0);
      wait_wr(base + 2, 40);
      chk("t3_order0", wr_log[wr_log.size() - 2], 8'h78);
      chk("t3_order1", wr_log[wr_log.size() - 1], 8'h11);

      // transmitter full holds the byte and pauses the host
      base = n_wr; rd0 = n_rd;
      push(8'h22, 1'b0);
      wait_rd(rd0 + 1, 20);
      tx_full = 1'b1;
      idle(200);
      chk("t4_no_wr_full", n_wr, base);
      chk("t4_cts_low", host_cts, 0);
      tx_full = 1'b0;
      wait_wr(base + 1, 10);
      chk("t4_data", last_data, 8'h23);
      idle(20);
      chk("t4_single_wr", n_wr, base + 1);
      chk("t4_cts_back", host_cts, 1);

      // host not ready keeps the byte parked
      host_rts = 1'b0;
      idle(5);
      base = n_wr;
      push(8'h30, 1'b0);
      idle(50);
      chk("rts_no_wr", n_wr, base);
      host_rts = 1'b1;
      wait_wr(base + 1, 10);
      chk("rts_data", last_data, 8'h31);

      // LED stretch: 10 cycles per event, retrigger 5 cycles later gives 15 with no gap
      idle(30);
      push(8'h5A, 1'b0);
      led_window(40, rh, th, rr, tr);
      chk("t5_rx_led_len", rh, 10);
      chk("t5_tx_led_len", th, 10);
      chk("t5_rx_led_rise", rr, 1);
      chk("t5_tx_led_rise", tr, 1);
      idle(20);
      push(8'h01, 1'b0); push(8'h02, 1'b0);
      led_window(60, rh, th, rr, tr);
      chk("t5_rx_led_ext", rh, 15);
      chk("t5_tx_led_ext", th, 15);
      chk("t5_rx_no_gap", rr, 1);
      chk("t5_tx_no_gap", tr, 1);
      chk("t5_last_data", last_data, 8'h03);

      // reset while waiting for data aborts the transaction
      rd0 = n_rd;
      push(8'h66, 1'b0);
      wait_rd(rd0 + 1, 20);
      rst = 1'b0;
      #1;
      chk("t6_async_reset", {rx_rd, tx_wr, tx_data, host_cts, rx_led, tx_led, echo_cnt}, '0);
      idle(3);
      rst = 1'b1;
      idle(20);
      chk("t6_lost_byte", echo_cnt, 16'd0);

      // byte received with an error flag
      push(8'h41, 1'b1);
      idle(20);
`ifdef SERIAL_ECHO_ERR_DROP_EN
      chk("t6_err_cnt", err_cnt, 16'd1);
      chk("t6_err_echo_cnt", echo_cnt, 16'd0);
`else
      chk("t6_err_echo_cnt", echo_cnt, 16'd1);
      chk("t6_err_data", last_data, 8'h42);
`endif
      base = n_wr;
      push(8'h42, 1'b0);
      wait_wr(base + 1, 20);
      chk("t6_after_err", last_data, 8'h43);
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
